// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner: scan FSM encoding, event layout
// and the key-code helper used to build event bytes.
package keypad_pkg;

    localparam int EVT_PRESS_BIT = 7;
    localparam int KEY_CODE_BITS = 7;

    typedef enum logic [1:0] {
        DRIVE  = 2'd0,
        SAMPLE = 2'd1,
        EMIT   = 2'd2,
        NEXT   = 2'd3
    } scanState_t;

    // Code 0 is reserved: the downstream FIFO reads 0x00 when empty.
    function automatic logic [KEY_CODE_BITS-1:0] key_code(input int row, input int col, input int cols);
        return KEY_CODE_BITS'(row * cols + col + 1);
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Event bus from the keypad scanner to the keyboard event FIFO, plus the
// debounced key map.
interface keypad_scanner_if #(
    parameter int EVT_WIDTH = 8,
    parameter int NUM_KEYS  = 16
);
    // evt_wr is a one-cycle valid strobe with no ready: the receiver must take
    // every pulse. Each pulse is followed by at least one low cycle, and
    // evt_data changes only with a pulse and holds until the next one.
    logic [EVT_WIDTH-1:0] evt_data;
    logic                 evt_wr;
    logic [NUM_KEYS-1:0]  key_state;

    modport master (output evt_data, output evt_wr, output key_state);
    modport slave  (input  evt_data, input  evt_wr, input  key_state);
endinterface

// File: rtl/keypad_scanner_debounce.sv
// Per-key debouncer: accepts a new level after DEB_SCANS consecutive samples
// that differ from the stable level, and strobes change on that sample.
module key_debounce #(
    parameter int DEB_SCANS = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic raw,
    output logic level,
    output logic change
);

    logic [1:0] cnt;
    logic       accept;

    assign accept = ({1'b0, cnt} + 3'd1) == 3'(DEB_SCANS);
    assign change = en && (raw != level) && accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= 2'd0;
            level <= 1'b0;
        end else if (en) begin
            if (raw == level) begin
                cnt <= 2'd0;
            end else if (accept) begin
                level <= raw;
                cnt   <= 2'd0;
            end else begin
                cnt <= cnt + 2'd1;
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Key-matrix scanner: drives one column at a time, debounces every key and
// writes one press/release byte per change. KEY_AUTOREPEAT_EN adds auto-repeat.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS          = 4,
    parameter int COLS          = 4,
    parameter int EVT_WIDTH     = 8,
    parameter int SETTLE_CYCLES = 16,
    parameter int DEB_SCANS     = 3,
    parameter int REPEAT_DELAY  = 32,
    parameter int REPEAT_RATE   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ROWS-1:0]    row_n,
    output logic [COLS-1:0]    col_n,
    keypad_scanner_if.master   evt,
    output scanState_t         dbgState
);

    localparam int NUM_KEYS = ROWS * COLS;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    scanState_t           state;
    logic [CW-1:0]        col;
    logic [RW-1:0]        rowIdx;
    logic [SW-1:0]        settleCnt;
    logic                 gap;
    logic [ROWS-1:0]      rowSync1, rowSync2, rawRows;
    logic [EVT_WIDTH-1:0] evtData, evtWord;
    logic                 evtWr;
    logic [NUM_KEYS-1:0]  keyLevel, keyChange, keyEn;
    logic                 stepActive, evtNow, newLevel, repNow, emitNow, emitPress;

    // A row step is live only in its first EMIT cycle; the second is the gap.
    assign stepActive = (state == EMIT) && !gap;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            assign keyEn[r*COLS+c] = stepActive && (rowIdx == RW'(r)) && (col == CW'(c));
            key_debounce #(.DEB_SCANS(DEB_SCANS)) uDeb (
                .clk    (clk),
                .rst    (rst),
                .en     (keyEn[r*COLS+c]),
                .raw    (rawRows[r]),
                .level  (keyLevel[r*COLS+c]),
                .change (keyChange[r*COLS+c])
            );
        end
    end

    assign evtNow    = |keyChange;
    assign newLevel  = rawRows[rowIdx];
    assign emitNow   = evtNow || repNow;
    assign emitPress = evtNow ? newLevel : 1'b1;

    always_comb begin
        evtWord                      = '0;
        evtWord[KEY_CODE_BITS-1:0]   = key_code(int'(rowIdx), int'(col), COLS);
        evtWord[EVT_PRESS_BIT]       = emitPress;
    end

    // Rows idle high (pulled up), so the synchroniser resets to all ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rowSync1 <= '1;
            rowSync2 <= '1;
        end else begin
            rowSync1 <= row_n;
            rowSync2 <= rowSync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= DRIVE;
            col       <= '0;
            rowIdx    <= '0;
            settleCnt <= '0;
            gap       <= 1'b0;
            rawRows   <= '0;
            evtData   <= '0;
            evtWr     <= 1'b0;
            col_n     <= '1;
        end else begin
            evtWr <= 1'b0;
            case (state)
                DRIVE: begin
                    col_n <= ~(COLS'(1) << col);
                    if (settleCnt == SW'(SETTLE_CYCLES - 1)) begin
                        settleCnt <= '0;
                        state     <= SAMPLE;
                    end else begin
                        settleCnt <= settleCnt + 1'b1;
                    end
                end
                SAMPLE: begin
                    rawRows <= ~rowSync2;
                    rowIdx  <= '0;
                    gap     <= 1'b0;
                    state   <= EMIT;
                end
                EMIT: begin
                    if (!gap && emitNow) begin
                        evtWr   <= 1'b1;
                        evtData <= evtWord;
                        gap     <= 1'b1;
                    end else begin
                        gap <= 1'b0;
                        if (rowIdx == RW'(ROWS - 1)) begin
                            rowIdx <= '0;
                            state  <= NEXT;
                        end else begin
                            rowIdx <= rowIdx + 1'b1;
                        end
                    end
                end
                NEXT: begin
                    col_n <= '1;
                    col   <= (col == CW'(COLS - 1)) ? '0 : col + 1'b1;
                    state <= DRIVE;
                end
                default: state <= DRIVE;
            endcase
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam int KW  = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int RMX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RCW = $clog2(RMX + 1);

    logic [KW-1:0]  repKey, curKey;
    logic [RCW-1:0] repCnt;
    logic           repValid, repPending;

    assign curKey = KW'(int'(rowIdx) * COLS + int'(col));
    // A debounce event on the same step takes priority; the repeat stays pending.
    assign repNow = stepActive && !evtNow && repValid && repPending && (repKey == curKey);

    // repCnt counts down full scans to the next repeat; a wrap at 1 arms it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            repValid   <= 1'b0;
            repPending <= 1'b0;
            repKey     <= '0;
            repCnt     <= '0;
        end else if (stepActive && evtNow) begin
            if (newLevel) begin
                repValid   <= 1'b1;
                repPending <= 1'b0;
                repKey     <= curKey;
                repCnt     <= RCW'(REPEAT_DELAY);
            end else if (curKey == repKey) begin
                repValid   <= 1'b0;
                repPending <= 1'b0;
            end
        end else if (repNow) begin
            repPending <= 1'b0;
        end else if (state == NEXT && col == CW'(COLS - 1) && repValid) begin
            if (repCnt == RCW'(1)) begin
                repCnt     <= RCW'(REPEAT_RATE);
                repPending <= 1'b1;
            end else begin
                repCnt <= repCnt - 1'b1;
            end
        end
    end
`else
    assign repNow = 1'b0;
`endif

    assign evt.evt_data  = evtData;
    assign evt.evt_wr    = evtWr;
    assign evt.key_state = keyLevel;
    assign dbgState      = state;

endmodule
